// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if
// Request/response bus of the ALU sequencer.
//   req_valid/req_ready : request handshake; req_op, req_a, req_b, req_dec carry the operation
//   rsp_valid/rsp_ready : response handshake; rsp_res is the result, rsp_flags is {N,V,Z,C}
// master: the requester (testbench / upstream); slave: the sequencer.
interface alu_sequencer_if;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_op;
   logic [7:0] req_a;
   logic [7:0] req_b;
   logic       req_dec;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_res;
   logic [3:0] rsp_flags;

   modport master (output req_valid, req_op, req_a, req_b, req_dec, rsp_ready,
                   input  req_ready, rsp_valid, rsp_res, rsp_flags);
   modport slave  (input  req_valid, req_op, req_a, req_b, req_dec, rsp_ready,
                   output req_ready, rsp_valid, rsp_res, rsp_flags);
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer
// Sequences 6502-style ALU operations onto an external combinational ALU.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : request channel (op/a/b/dec) and response channel (res, flags {N,V,Z,C})
//   sum_en..sr_en     : ALU function select (at most one high), inv_en inverts alu_b for the adder
//   alu_a/alu_b/alu_cin : ALU operands
//   alu_res/alu_cout  : ALU results, combinational from the operands in the same cycle
// Optional feature: define ALU_SEQUENCER_DECIMAL_EN to enable BCD correction for ADC/SBC
// when req_dec=1 (one extra FIX cycle). Without it req_dec is ignored.
module alu_sequencer (
   input  logic           clk,
   input  logic           rst_n,
   alu_sequencer_if.slave bus,
   output logic           sum_en,
   output logic           and_en,
   output logic           eor_en,
   output logic           or_en,
   output logic           sr_en,
   output logic           inv_en,
   output logic [7:0]     alu_a,
   output logic [7:0]     alu_b,
   output logic           alu_cin,
   input  logic [7:0]     alu_res,
   input  logic           alu_cout
);
   localparam logic [3:0] OP_ADC = 4'd0, OP_SBC = 4'd1, OP_AND = 4'd2, OP_EOR = 4'd3,
                          OP_ORA = 4'd4, OP_CMP = 4'd5, OP_ASL = 4'd6, OP_LSR = 4'd7,
                          OP_ROL = 4'd8, OP_ROR = 4'd9, OP_CLC = 4'd10, OP_SEC = 4'd11;

   typedef enum logic [1:0] {IDLE, EXEC, FIX, RESP} state_t;
   state_t state, nxt;

   logic [3:0] op_r;
   logic [7:0] a_r, b_r;
   logic [7:0] bin_res_r;
   logic       cout_r, v_r;
   logic [7:0] res_r;
   logic [3:0] flags_r;
   logic       c_in, v_now, need_fix;
   logic [1:0] res_nz;
   logic [7:0] fin_res;
   logic [3:0] fin_flags;
   logic       fin_c, fin_v;

   function automatic logic [1:0] nz_of(input logic [7:0] r);
      return {r[7], (r == 8'd0)};
   endfunction

   assign c_in   = flags_r[0];
   assign res_nz = nz_of(alu_res);
   // Binary overflow of the adder: b' is the inverted operand for SBC.
   assign v_now  = (a_r[7] == ((op_r == OP_SBC) ? ~b_r[7] : b_r[7])) & (alu_res[7] != a_r[7]);

`ifdef ALU_SEQUENCER_DECIMAL_EN
   logic       dec_r;
   logic [7:0] corr, corr_r;
   logic [4:0] lo_sum;
   logic       lo_fix, hi_fix;

   // Correction amount is derived from the binary EXEC result and applied in FIX.
   always_comb begin
      if (op_r == OP_SBC) begin
         lo_sum = {1'b0, a_r[3:0]} + {1'b0, ~b_r[3:0]} + {4'd0, c_in};
         lo_fix = ~lo_sum[4];
         hi_fix = ~alu_cout;
      end else begin
         lo_sum = {1'b0, a_r[3:0]} + {1'b0, b_r[3:0]} + {4'd0, c_in};
         lo_fix = (lo_sum > 5'd9);
         hi_fix = alu_cout | (alu_res > 8'h99);
      end
      corr = {1'b0, hi_fix, hi_fix, 2'b00, lo_fix, lo_fix, 1'b0};
   end

   assign need_fix = (op_r == OP_ROR) || (dec_r && ((op_r == OP_ADC) || (op_r == OP_SBC)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_r  <= 1'b0;
         corr_r <= 8'd0;
      end else begin
         if (state == IDLE && bus.req_valid) dec_r <= bus.req_dec;
         if (state == EXEC) corr_r <= corr;
      end
   end
`else
   logic unused_dec;
   assign unused_dec = bus.req_dec;
   assign need_fix   = (op_r == OP_ROR);
`endif

   // ---- state register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   // ---- next state ----
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (bus.req_valid) nxt = EXEC;
         EXEC:    nxt = need_fix ? FIX : RESP;
         FIX:     nxt = RESP;
         RESP:    if (bus.rsp_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // ---- outputs: handshake and ALU drive ----
   always_comb begin
      bus.req_ready = (state == IDLE);
      bus.rsp_valid = (state == RESP);
      sum_en  = 1'b0;
      and_en  = 1'b0;
      eor_en  = 1'b0;
      or_en   = 1'b0;
      sr_en   = 1'b0;
      inv_en  = 1'b0;
      alu_a   = 8'd0;
      alu_b   = 8'd0;
      alu_cin = 1'b0;
      if (state == EXEC) begin
         alu_a = a_r;
         alu_b = b_r;
         case (op_r)
            OP_ADC: begin sum_en = 1'b1; alu_cin = c_in; end
            OP_SBC: begin sum_en = 1'b1; inv_en = 1'b1; alu_cin = c_in; end
            OP_CMP: begin sum_en = 1'b1; inv_en = 1'b1; alu_cin = 1'b1; end
            OP_AND: and_en = 1'b1;
            OP_EOR: eor_en = 1'b1;
            OP_ORA: or_en  = 1'b1;
            OP_ASL: begin sum_en = 1'b1; alu_b = a_r; end
            OP_ROL: begin sum_en = 1'b1; alu_b = a_r; alu_cin = c_in; end
            OP_LSR, OP_ROR: sr_en = 1'b1;
            default: ;
         endcase
      end else if (state == FIX) begin
         alu_a = bin_res_r;
         if (op_r == OP_ROR) begin
            // Old carry rotates into bit 7; flags_r is not updated until RESP.
            or_en = 1'b1;
            alu_b = {c_in, 7'd0};
         end
`ifdef ALU_SEQUENCER_DECIMAL_EN
         else if (op_r == OP_SBC) begin
            sum_en  = 1'b1;
            inv_en  = 1'b1;
            alu_b   = corr_r;
            alu_cin = 1'b1;
         end else begin
            sum_en = 1'b1;
            alu_b  = corr_r;
         end
`endif
      end
   end

   // Final result and flags, valid in the last ALU step (EXEC or FIX).
   always_comb begin
      fin_res   = alu_res;
      fin_flags = flags_r;
      fin_c     = alu_cout;
      fin_v     = v_now;
      if (state == FIX) begin
         fin_v = v_r;
         fin_c = (op_r == OP_ADC) ? (cout_r | alu_cout) : cout_r;
      end
      case (op_r)
         OP_ADC, OP_SBC:                 fin_flags = {res_nz[1], fin_v, res_nz[0], fin_c};
         OP_CMP: begin
            fin_res   = a_r;
            fin_flags = {res_nz[1], flags_r[2], res_nz[0], alu_cout};
         end
         OP_AND, OP_EOR, OP_ORA:         fin_flags = {res_nz[1], flags_r[2], res_nz[0], flags_r[0]};
         OP_ASL, OP_LSR, OP_ROL, OP_ROR: fin_flags = {res_nz[1], flags_r[2], res_nz[0], fin_c};
         OP_CLC: begin fin_res = a_r; fin_flags = {flags_r[3:1], 1'b0}; end
         OP_SEC: begin fin_res = a_r; fin_flags = {flags_r[3:1], 1'b1}; end
         default: fin_res = 8'd0;
      endcase
   end

   // ---- operand latch, EXEC capture, flag update on entry to RESP ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r      <= 4'd0;
         a_r       <= 8'd0;
         b_r       <= 8'd0;
         bin_res_r <= 8'd0;
         cout_r    <= 1'b0;
         v_r       <= 1'b0;
         res_r     <= 8'd0;
         flags_r   <= 4'd0;
      end else begin
         if (state == IDLE && bus.req_valid) begin
            op_r <= bus.req_op;
            a_r  <= bus.req_a;
            b_r  <= bus.req_b;
         end
         if (state == EXEC) begin
            bin_res_r <= alu_res;
            cout_r    <= alu_cout;
            v_r       <= v_now;
         end
         if ((state == EXEC || state == FIX) && nxt == RESP) begin
            res_r   <= fin_res;
            flags_r <= fin_flags;
         end
      end
   end

   assign bus.rsp_res   = res_r;
   assign bus.rsp_flags = flags_r;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
// Scoreboard bench for alu_sequencer: a behavioural model predicts result, flags and latency
// at issue time; a monitor compares whenever a response is presented.
// Honours ALU_SEQUENCER_DECIMAL_EN for the BCD vectors.
module tb_alu_sequencer;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_sequencer_if bus();
   logic       sum_en, and_en, eor_en, or_en, sr_en, inv_en;
   logic [7:0] alu_a, alu_b, alu_res;
   logic       alu_cin, alu_cout;

   alu_sequencer dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .sum_en(sum_en), .and_en(and_en), .eor_en(eor_en), .or_en(or_en),
      .sr_en(sr_en), .inv_en(inv_en),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
      .alu_res(alu_res), .alu_cout(alu_cout)
   );

   // External combinational ALU.
   logic [7:0] alu_bq;
   logic [8:0] alu_sum;
   always_comb begin
      alu_bq   = inv_en ? ~alu_b : alu_b;
      alu_sum  = {1'b0, alu_a} + {1'b0, alu_bq} + {8'd0, alu_cin};
      alu_res  = 8'd0;
      alu_cout = 1'b0;
      if (sum_en) begin
         alu_res  = alu_sum[7:0];
         alu_cout = alu_sum[8];
      end else if (and_en) alu_res = alu_a & alu_b;
      else if (eor_en)     alu_res = alu_a ^ alu_b;
      else if (or_en)      alu_res = alu_a | alu_b;
      else if (sr_en) begin
         alu_res  = {1'b0, alu_a[7:1]};
         alu_cout = alu_a[0];
      end
   end

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   logic m_n = 1'b0, m_v = 1'b0, m_z = 1'b0, m_c = 1'b0;

`ifdef ALU_SEQUENCER_DECIMAL_EN
   function automatic int bcd2i(input logic [7:0] x);
      return int'(x[7:4]) * 10 + int'(x[3:0]);
   endfunction
   function automatic logic [7:0] i2bcd(input int x);
      return {4'(x / 10), 4'(x % 10)};
   endfunction
`endif

   task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic dec, output logic [7:0] res, output int lat);
      int s, sv, sa, sb, c0;
      logic [7:0] nzv;
      bit upd_nz;
      res = 8'd0; lat = 2; upd_nz = 1'b1;
      c0 = int'(m_c);
      sa = int'($signed(a));
      sb = int'($signed(b));
      case (op)
         4'd0: begin
            s = int'(a) + int'(b) + c0;  res = 8'(s);  m_c = (s > 255);
            sv = sa + sb + c0;            m_v = (sv > 127) || (sv < -128);
`ifdef ALU_SEQUENCER_DECIMAL_EN
            if (dec) begin
               s = bcd2i(a) + bcd2i(b) + c0;
               m_c = (s >= 100); res = i2bcd(s % 100); lat = 3;
            end
`endif
         end
         4'd1: begin
            s = int'(a) - int'(b) - (1 - c0);  res = 8'(s);  m_c = (s >= 0);
            sv = sa - sb - (1 - c0);            m_v = (sv > 127) || (sv < -128);
`ifdef ALU_SEQUENCER_DECIMAL_EN
            if (dec) begin
               s = bcd2i(a) - bcd2i(b) - (1 - c0);
               m_c = (s >= 0); if (s < 0) s = s + 100;
               res = i2bcd(s); lat = 3;
            end
`endif
         end
         4'd2: res = a & b;
         4'd3: res = a ^ b;
         4'd4: res = a | b;
         4'd5: begin res = a; m_c = (a >= b); end
         4'd6: begin res = 8'(a * 2);      m_c = (a >= 8'd128); end
         4'd7: begin res = a / 2;          m_c = ((a % 2) != 0); end
         4'd8: begin res = 8'(a * 2 + c0); m_c = (a >= 8'd128); end
         4'd9: begin res = 8'(c0 * 128 + int'(a / 2)); m_c = ((a % 2) != 0); lat = 3; end
         4'd10: begin res = a; m_c = 1'b0; upd_nz = 1'b0; end
         4'd11: begin res = a; m_c = 1'b1; upd_nz = 1'b0; end
         default: upd_nz = 1'b0;
      endcase
      nzv = (op == 4'd5) ? 8'(int'(a) - int'(b)) : res;
      if (upd_nz) begin
         m_n = (nzv >= 8'd128);
         m_z = (nzv == 8'd0);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct { logic [7:0] res; logic [3:0] flags; int lat; int acc; } exp_t;
   exp_t sb[$];

   task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic dec);
      exp_t e;
      int n;
      @(negedge clk);
      bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_dec = dec;
      bus.req_valid = 1'b1;
      n = 0;
      while (!bus.req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) begin
         chk("accept_timeout", int'(bus.req_ready), 1);
         bus.req_valid = 1'b0;
         return;
      end
      model(op, a, b, dec, e.res, e.lat);
      e.flags = {m_n, m_v, m_z, m_c};
      e.acc = cyc;
      sb.push_back(e);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_op = 4'($urandom); bus.req_a = 8'($urandom); bus.req_b = 8'($urandom);
      bus.req_dec = 1'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", sb.size(), 0);
      @(negedge clk);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_req_ready"}, bus.req_ready, 1);
      chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
      chk({tag, "_rsp_res"}, bus.rsp_res, 0);
      chk({tag, "_flags"}, bus.rsp_flags, 0);
      chk({tag, "_enables"}, {sum_en, and_en, eor_en, or_en, sr_en, inv_en}, 0);
      chk({tag, "_alu_ops"}, {alu_a, alu_b, alu_cin}, 0);
   endtask

   // rsp_ready is driven a little after each rising edge.
   bit   rand_rdy = 1'b0;
   logic force_rdy = 1'b1;
   always @(posedge clk) begin
      #2;
      bus.rsp_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : force_rdy;
   end

   // ---------------- monitor ----------------
   int rise = 0;
   bit seen = 1'b0;
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("alu_onehot", int'($countones({sum_en, and_en, eor_en, or_en, sr_en}) <= 1), 1);
         if (bus.req_ready || bus.rsp_valid)
            chk("idle_resp_enables", {sum_en, and_en, eor_en, or_en, sr_en, inv_en}, 0);
         if (bus.rsp_valid) begin
            chk("req_ready_in_resp", bus.req_ready, 0);
            if (!seen) begin
               rise = cyc;
               seen = 1'b1;
            end
            if (sb.size() == 0) chk("unexpected_rsp", bus.rsp_valid, 0);
            else begin
               chk("rsp_res", bus.rsp_res, sb[0].res);
               chk("rsp_flags", bus.rsp_flags, sb[0].flags);
               if (bus.rsp_ready) begin
                  chk("latency", rise - sb[0].acc, sb[0].lat);
                  void'(sb.pop_front());
                  seen = 1'b0;
               end
            end
         end
      end else seen = 1'b0;
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [3:0] op;
      logic [7:0] a, b;
      logic       dec;
      int         n;
      rst_n = 1'b0;
      bus.req_valid = 1'b0; bus.req_op = 4'd0; bus.req_a = 8'd0; bus.req_b = 8'd0; bus.req_dec = 1'b0;
      #1;
      chk_zero_outputs("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors
      send(4'd11, 8'h5A, 8'h00, 1'b0);   // SEC
      send(4'd0,  8'h7F, 8'h01, 1'b0);   // ADC -> 0x81, N V
      send(4'd10, 8'h33, 8'h00, 1'b0);   // CLC
      send(4'd1,  8'h00, 8'h00, 1'b0);   // SBC -> 0xFF, N
      send(4'd11, 8'h00, 8'h00, 1'b0);   // SEC
      send(4'd9,  8'h01, 8'h00, 1'b0);   // ROR -> 0x80, C, latency 3
      send(4'd5,  8'h80, 8'h80, 1'b0);   // CMP equal -> Z C
      drain();

      // Back-pressure: response held for several cycles
      force_rdy = 1'b0;
      send(4'd6, 8'hC0, 8'h00, 1'b0);    // ASL -> 0x80, C
      repeat (6) @(negedge clk);
      chk("stall_rsp_valid", bus.rsp_valid, 1);
      chk("stall_req_ready", bus.req_ready, 0);
      force_rdy = 1'b1;
      drain();
      send(4'd14, 8'hAA, 8'h55, 1'b0);   // illegal -> 0, flags unchanged
      drain();

`ifdef ALU_SEQUENCER_DECIMAL_EN
      send(4'd10, 8'h00, 8'h00, 1'b0);
      send(4'd0,  8'h45, 8'h38, 1'b1);   // -> 0x83, C=0
      send(4'd0,  8'h99, 8'h01, 1'b1);   // -> 0x00, C=1
      drain();
`endif

      // Randomized traffic with random response back-pressure
      rand_rdy = 1'b1;
      repeat (300) begin
         op  = 4'($urandom_range(0, 15));
         a   = 8'($urandom);
         b   = 8'($urandom);
         dec = 1'($urandom);
`ifdef ALU_SEQUENCER_DECIMAL_EN
         if (dec && op < 4'd2) begin
            a = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         end
`endif
         send(op, a, b, dec);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();
      rand_rdy = 1'b0;
      force_rdy = 1'b1;
      @(negedge clk);

      // Reset during EXEC of an ADC: op aborted, no response, flags cleared
      send(4'd11, 8'h00, 8'h00, 1'b0);   // make C=1 so flags are non-zero
      drain();
      @(negedge clk);
      bus.req_op = 4'd0; bus.req_a = 8'h7F; bus.req_b = 8'h01; bus.req_dec = 1'b0;
      bus.req_valid = 1'b1;
      n = 0;
      while (!bus.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("midop_accept", bus.req_ready, 1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("midop_exec_sum_en", sum_en, 1);
      rst_n = 1'b0;
      #1;
      chk_zero_outputs("midop_reset");
      m_n = 1'b0; m_v = 1'b0; m_z = 1'b0; m_c = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_rst_flags", bus.rsp_flags, 0);
      chk("post_rst_req_ready", bus.req_ready, 1);
      send(4'd0, 8'h01, 8'h01, 1'b0);    // ADC with C=0 after reset -> 0x02
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
